apb_sram_slave: RTL and testbench

- Parametrised APB4 slave wrapping an internal single-port synchronous word memory. Next-generation replacement for the fixed 8-bit APB memory slave.
- Adds configurable data width, address width, depth and wait states.
- Adds byte-lane write strobes (pstrb) and a slave error response (pslverr) for illegal accesses.
- Sits on the peripheral bus behind the APB bridge/master; one transfer in flight at a time.

---
 rtl/apb_sram_slave.sv | 142 ++++++++++++++
 tb/tb_apb_sram_slave.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_sram_slave.sv
// APB4 slave in front of a single-port synchronous word memory with byte-lane
// strobes, programmable wait states and an error response for illegal addresses.
module apb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW = ADDR_WIDTH - LB;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [MW-1:0]           idx_q, idx_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           strb_q, strb_d;
  logic [DATA_WIDTH-1:0]   prdata_q;
  logic                    access;
  logic [NB-1:0]           lane_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [IW-1:0]           word_idx;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    addr_err;

  assign word_idx     = paddr[ADDR_WIDTH-1:LB];
  assign out_of_range = ({1'b0, word_idx} >= (IW+1)'(DEPTH));
  assign addr_err     = misaligned | out_of_range;

  generate
    if (LB > 0) begin : g_align
      assign misaligned = |paddr[LB-1:0];
    end else begin : g_byte_bus
      assign misaligned = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          idx_d   = word_idx[MW-1:0];
          write_d = pwrite;
          err_d   = addr_err;
          wdata_d = pwdata;
          strb_d  = pstrb;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Dropping psel mid-transfer abandons it without touching memory.
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_we[gi] = presetn & access & write_q & ~err_q & strb_q[gi];
    end
  endgenerate

  always_ff @(posedge pclk) begin
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

  // Reads and any errored access load prdata; clean writes leave it alone.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      prdata_q <= '0;
    end else if (access && (err_q || !write_q)) begin
      prdata_q <= err_q ? '0 : mem[idx_q];
    end
  end

  assign prdata  = prdata_q;
  assign pready  = (state_q == ST_RESP);
  assign pslverr = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_apb_sram_slave.sv
// Bench for apb_sram_slave: one instance with no wait states, one with three,
// checked cycle by cycle against a byte-addressed reference memory.
module tb_apb_sram_slave;

  logic              clk = 1'b0;
  logic [1:0]        rstn;
  logic [1:0]        psel;
  logic              penable, pwrite;
  logic [11:0]       paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [1:0][31:0]  prdata;
  logic [1:0]        pready, pslverr;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_resp_cyc;

  logic [7:0] bmem  [2][1024];
  bit         known [2][1024];
  logic [31:0] last_rd [2];
  bit          last_ok [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .pclk(clk), .presetn(rstn[0]), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(256), .WAIT_STATES(3)) u_dut1 (
    .pclk(clk), .presetn(rstn[1]), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer on instance d, starting in the setup cycle and
  // returning in the cycle right after the response.
  task automatic xfer(input int d, input bit wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd);
    int w;
    bit err_e, known_e;
    logic [31:0] exp_d;
    w = (d == 0) ? 0 : 3;
    err_e = (a[1:0] != 2'b00) || (a >= 12'h400);
    exp_d = '0;
    known_e = 1'b1;
    if (err_e) begin
      exp_d = '0;
    end else if (wr) begin
      exp_d = last_rd[d];
      known_e = last_ok[d];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!known[d][int'(a) + i]) known_e = 1'b0;
        exp_d[8*i +: 8] = bmem[d][int'(a) + i];
      end
    end
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st; penable = 1'b0;
    psel[d] = 1'b1;
    @(negedge clk);
    check_eq($sformatf("d%0d %s %h pready c0", d, wr ? "wr" : "rd", a), pready[d], 1'b0);
    for (int k = 1; k <= 2 + w; k++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      check_eq($sformatf("d%0d %s %h pready c%0d", d, wr ? "wr" : "rd", a, k),
               pready[d], (k == 2 + w));
      if (k < 2 + w)
        check_eq($sformatf("d%0d %s %h pslverr c%0d", d, wr ? "wr" : "rd", a, k), pslverr[d], 1'b0);
    end
    check_eq($sformatf("d%0d %s %h pslverr", d, wr ? "wr" : "rd", a), pslverr[d], err_e);
    if (known_e) check_eq($sformatf("d%0d %s %h prdata", d, wr ? "wr" : "rd", a), prdata[d], exp_d);
    rd = prdata[d];
    last_resp_cyc = cyc;
    $display("xfer d%0d %s addr=%h wdata=%h strb=%h -> prdata=%h pslverr=%0d",
             d, wr ? "WR" : "RD", a, wd, st, prdata[d], pslverr[d]);
    if (wr && !err_e) begin
      for (int i = 0; i < 4; i++) begin
        if (st[i]) begin
          bmem[d][int'(a) + i] = wd[8*i +: 8];
          known[d][int'(a) + i] = 1'b1;
        end
      end
    end else begin
      last_rd[d] = exp_d;
      last_ok[d] = known_e;
    end
    @(posedge clk); #1;
    psel[d] = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int c0, c1;
    rstn = 2'b00; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = '0; last_ok[d] = 1'b1;
      for (int i = 0; i < 1024; i++) known[d][i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rstn = 2'b11;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d reset pready", d), pready[d], 1'b0);
      check_eq($sformatf("d%0d reset pslverr", d), pslverr[d], 1'b0);
      check_eq($sformatf("d%0d reset prdata", d), prdata[d], 32'h0);
    end
    @(posedge clk); #1;

    // Basic write/read, partial strobes, empty strobe, error responses
    xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, rd);
    xfer(0, 0, 12'h010, 32'h0, 4'h0, rd);
    check_eq("t1 read literal", rd, 32'hDEADBEEF);
    xfer(0, 1, 12'h020, 32'h11223344, 4'hF, rd);
    xfer(0, 1, 12'h020, 32'hAABBCCDD, 4'b0101, rd);
    xfer(0, 0, 12'h020, 32'h0, 4'h0, rd);
    check_eq("t2 merge literal", rd, 32'h11BB33DD);
    xfer(0, 1, 12'h020, 32'hFFFFFFFF, 4'h0, rd);
    xfer(0, 0, 12'h020, 32'h0, 4'h0, rd);
    check_eq("t2 zero strobe literal", rd, 32'h11BB33DD);
    xfer(0, 1, 12'h000, 32'h01020304, 4'hF, rd);
    xfer(0, 1, 12'h400, 32'h00000055, 4'hF, rd);
    xfer(0, 0, 12'h000, 32'h0, 4'h0, rd);
    check_eq("t3 unchanged literal", rd, 32'h01020304);
    xfer(0, 0, 12'h012, 32'h0, 4'h0, rd);
    check_eq("t3 misaligned literal", rd, 32'h0);

    // Three wait states on the second instance
    xfer(1, 1, 12'h010, 32'hDEADBEEF, 4'hF, rd);
    xfer(1, 0, 12'h010, 32'h0, 4'h0, rd);
    check_eq("t4 read literal", rd, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("t4 pready after resp", pready[1], 1'b0);
    @(posedge clk); #1;

    // Reset while a write is in its wait cycle
    xfer(0, 1, 12'h030, 32'h0, 4'hF, rd);
    xfer(0, 0, 12'h010, 32'h0, 4'h0, rd);
    pwrite = 1'b1; paddr = 12'h030; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    penable = 1'b0; psel[0] = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1; rstn[0] = 1'b0;
    @(posedge clk); #1;
    rstn[0] = 1'b1; psel[0] = 1'b0; penable = 1'b0;
    @(negedge clk);
    check_eq("t5 reset pready", pready[0], 1'b0);
    check_eq("t5 reset pslverr", pslverr[0], 1'b0);
    check_eq("t5 reset prdata", prdata[0], 32'h0);
    $display("xfer d0 WR addr=030 aborted by reset");
    last_rd[0] = '0; last_ok[0] = 1'b1;
    @(posedge clk); #1;
    xfer(0, 0, 12'h030, 32'h0, 4'h0, rd);
    check_eq("t5 dropped write literal", rd, 32'h0);

    // Back-to-back reads
    xfer(0, 1, 12'h004, 32'h0BADF00D, 4'hF, rd);
    xfer(0, 1, 12'h008, 32'h76543210, 4'hF, rd);
    xfer(0, 0, 12'h000, 32'h0, 4'h0, rd);
    c0 = last_resp_cyc;
    xfer(0, 0, 12'h004, 32'h0, 4'h0, rd);
    check_eq("t6 spacing 1", 64'(last_resp_cyc - c0), 64'd3);
    check_eq("t6 data 1", rd, 32'h0BADF00D);
    c1 = last_resp_cyc;
    xfer(0, 0, 12'h008, 32'h0, 4'h0, rd);
    check_eq("t6 spacing 2", 64'(last_resp_cyc - c1), 64'd3);
    check_eq("t6 data 2", rd, 32'h76543210);

    // Randomized traffic against the reference memory
    for (int n = 0; n < 60; n++) begin
      int d, r;
      bit wr;
      logic [11:0] a;
      d = int'($urandom_range(1, 0));
      wr = 1'($urandom_range(1, 0));
      r = int'($urandom_range(9, 0));
      if (r == 0)      a = 12'(12'h400 + $urandom_range(255, 0) * 4);
      else if (r == 1) a = 12'($urandom_range(15, 0) * 4 + $urandom_range(3, 1));
      else             a = 12'($urandom_range(15, 0) * 4);
      xfer(d, wr, a, $urandom, 4'($urandom_range(15, 0)), rd);
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
